execute_stage: RTL and testbench

Execute (EX) stage of the 32-bit five-stage pipeline, directly downstream of instruction decode. Registers the decoded operands (ID/EX latch), performs ALU, address and branch-condition computation, and runs 32-bit multiplies on a 32-cycle iterative shift-add unit that stalls decode through a ready handshake. Results feed the memory-access stage; HLT is captured and frozen here.

---
 rtl/execute_stage.sv | 218 +++++++++++++++++++++
 tb/tb_execute_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// EX stage: ID/EX latch, ALU/address/branch evaluation, 32-cycle shift-add multiplier
// and sticky halt capture. Results are registered for the memory-access stage.
module execute_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] D,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] NPC_id,
  input  logic [XLEN-1:0] IR_id,
  input  logic            hlt,
  output logic            ex_valid,
  output logic [XLEN-1:0] ALUOut,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] IR_ex,
  output logic [XLEN-1:0] NPC_ex,
  output logic            cond,
  output logic [XLEN-1:0] br_target,
  output logic            hlt_ex
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES) + 1;

  localparam logic [5:0] OpAdd  = 6'h00;
  localparam logic [5:0] OpSub  = 6'h01;
  localparam logic [5:0] OpAnd  = 6'h02;
  localparam logic [5:0] OpOr   = 6'h03;
  localparam logic [5:0] OpXor  = 6'h04;
  localparam logic [5:0] OpSlt  = 6'h05;
  localparam logic [5:0] OpMul  = 6'h06;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpSubi = 6'h09;
  localparam logic [5:0] OpSlti = 6'h0A;
  localparam logic [5:0] OpLw   = 6'h0B;
  localparam logic [5:0] OpSw   = 6'h0C;
  localparam logic [5:0] OpBeqz = 6'h0D;
  localparam logic [5:0] OpBnez = 6'h0E;
  localparam logic [5:0] OpHlt  = 6'h3F;

  typedef enum logic [1:0] {StIdle, StMulBusy, StHalted} state_e;

  state_e          r_state;
  state_e          w_state_next;

  logic [XLEN-1:0] r_alu_out;
  logic [XLEN-1:0] r_store_data;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_npc;
  logic [XLEN-1:0] r_br_target;
  logic            r_cond;
  logic            r_ex_valid;
  logic            r_hlt;

  // Multiplier working registers plus the MUL's pass-through fields, held until completion
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CntW-1:0] r_cnt;
  logic [XLEN-1:0] r_mul_ir;
  logic [XLEN-1:0] r_mul_npc;
  logic [XLEN-1:0] r_mul_d;
  logic [XLEN-1:0] r_mul_br;

  logic [5:0]      w_opcode;
  logic            w_accept;
  logic            w_is_hlt;
  logic            w_is_mul;
  logic            w_mul_done;
  logic            w_cond;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_partial;

  assign ex_ready = (r_state == StIdle);

  always_comb begin
    w_opcode    = IR_id[31:26];
    w_accept    = in_valid && ex_ready;
    w_is_hlt    = hlt || (w_opcode == OpHlt);
    w_is_mul    = !w_is_hlt && (w_opcode == OpMul);
    w_br_target = NPC_id + Imm;
    w_mul_done  = (r_state == StMulBusy) && (r_cnt == CntW'(MUL_CYCLES - 1));
    w_partial   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  end

  always_comb begin
    w_alu  = '0;
    w_cond = 1'b0;
    unique case (w_opcode)
      OpAdd:       w_alu = A + B;
      OpSub:       w_alu = A - B;
      OpAnd:       w_alu = A & B;
      OpOr:        w_alu = A | B;
      OpXor:       w_alu = A ^ B;
      OpSlt:       w_alu = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OpAddi:      w_alu = A + Imm;
      OpSubi:      w_alu = A - Imm;
      OpSlti:      w_alu = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(Imm))};
      OpLw, OpSw:  w_alu = A + Imm;
      OpBeqz: begin
        w_alu  = w_br_target;
        w_cond = (A == '0);
      end
      OpBnez: begin
        w_alu  = w_br_target;
        w_cond = (A != '0);
      end
      default:     w_alu = '0;
    endcase
    // The hlt flag overrides whatever the opcode decodes to
    if (w_is_hlt) begin
      w_alu  = '0;
      w_cond = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && w_is_hlt) begin
          w_state_next = StHalted;
        end else if (w_accept && w_is_mul) begin
          w_state_next = StMulBusy;
        end
      end
      StMulBusy: if (w_mul_done) w_state_next = StIdle;
      StHalted:  w_state_next = StHalted;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out    <= '0;
      r_store_data <= '0;
      r_ir         <= '0;
      r_npc        <= '0;
      r_br_target  <= '0;
      r_cond       <= 1'b0;
      r_ex_valid   <= 1'b0;
      r_hlt        <= 1'b0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_mul_ir     <= '0;
      r_mul_npc    <= '0;
      r_mul_d      <= '0;
      r_mul_br     <= '0;
    end else begin
      r_ex_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept && w_is_mul) begin
            r_mcand   <= A;
            r_mplier  <= B;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_mul_ir  <= IR_id;
            r_mul_npc <= NPC_id;
            r_mul_d   <= D;
            r_mul_br  <= w_br_target;
          end else if (w_accept) begin
            r_alu_out    <= w_alu;
            r_store_data <= D;
            r_ir         <= IR_id;
            r_npc        <= NPC_id;
            r_br_target  <= w_br_target;
            r_cond       <= w_cond;
            r_ex_valid   <= 1'b1;
            if (w_is_hlt) r_hlt <= 1'b1;
          end
        end
        StMulBusy: begin
          r_acc    <= w_partial;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CntW'(1);
          if (w_mul_done) begin
            r_alu_out    <= w_partial;
            r_store_data <= r_mul_d;
            r_ir         <= r_mul_ir;
            r_npc        <= r_mul_npc;
            r_br_target  <= r_mul_br;
            r_cond       <= 1'b0;
            r_ex_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ALUOut     = r_alu_out;
  assign store_data = r_store_data;
  assign IR_ex      = r_ir;
  assign NPC_ex     = r_npc;
  assign br_target  = r_br_target;
  assign cond       = r_cond;
  assign ex_valid   = r_ex_valid;
  assign hlt_ex     = r_hlt;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases plus randomized instructions checked against
// an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        ex_ready;
  logic [31:0] A, B, D, Imm, NPC_id, IR_id;
  logic        hlt;
  logic        ex_valid;
  logic [31:0] ALUOut, store_data, IR_ex, NPC_ex, br_target;
  logic        cond;
  logic        hlt_ex;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] HltWord = 32'hFC00_0000;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ex_ready  (ex_ready),
    .A         (A),
    .B         (B),
    .D         (D),
    .Imm       (Imm),
    .NPC_id    (NPC_id),
    .IR_id     (IR_id),
    .hlt       (hlt),
    .ex_valid  (ex_valid),
    .ALUOut    (ALUOut),
    .store_data(store_data),
    .IR_ex     (IR_ex),
    .NPC_ex    (NPC_ex),
    .cond      (cond),
    .br_target (br_target),
    .hlt_ex    (hlt_ex)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    logic [31:0] r;
    r = $urandom;
    return {op, r[25:0]};
  endfunction

  // Reference: what ALUOut must hold for an instruction, from the ISA rules
  function automatic logic [31:0] ref_alu(input logic [31:0] ir, a, b, imm, npc, input logic h);
    logic [63:0] prod;
    if (h || ir[31:26] == 6'h3F) return 32'h0;
    prod = {32'h0, a} * {32'h0, b};
    case (ir[31:26])
      6'h00:        return a + b;
      6'h01:        return a - b;
      6'h02:        return a & b;
      6'h03:        return a | b;
      6'h04:        return a ^ b;
      6'h05:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h06:        return prod[31:0];
      6'h08:        return a + imm;
      6'h09:        return a - imm;
      6'h0A:        return ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      6'h0B, 6'h0C: return a + imm;
      6'h0D, 6'h0E: return npc + imm;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [31:0] ir, a, input logic h);
    if (h) return 1'b0;
    if (ir[31:26] == 6'h0D) return a == 0;
    if (ir[31:26] == 6'h0E) return a != 0;
    return 1'b0;
  endfunction

  // Called at a negedge with the stage idle; returns at the negedge where ex_valid shows.
  task automatic exec(input string tag, input logic [31:0] ir, a, b, d, imm, npc,
                      input logic h);
    int          lat;
    int          low;
    logic        is_mul;
    logic        is_hlt;
    logic [31:0] e_alu;
    logic        e_cond;
    is_hlt = h || ir[31:26] == 6'h3F;
    is_mul = !is_hlt && ir[31:26] == 6'h06;
    e_alu  = ref_alu(ir, a, b, imm, npc, h);
    e_cond = ref_cond(ir, a, h);
    chk({tag, "_ready_in"}, {31'h0, ex_ready}, 32'd1);
    IR_id = ir; A = a; B = b; D = d; Imm = imm; NPC_id = npc; hlt = h; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    hlt = 1'b0;
    lat = 1;
    low = 0;
    forever begin
      if (!ex_ready) low++;
      if (ex_valid || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {31'h0, ex_valid}, 32'd1);
    chk({tag, "_latency"}, 32'(lat), is_mul ? 32'd33 : 32'd1);
    chk({tag, "_ready_low"}, 32'(low), is_mul ? 32'd32 : (is_hlt ? 32'd1 : 32'd0));
    chk({tag, "_alu"}, ALUOut, e_alu);
    chk({tag, "_sdata"}, store_data, d);
    chk({tag, "_ir"}, IR_ex, ir);
    chk({tag, "_npc"}, NPC_ex, npc);
    chk({tag, "_cond"}, {31'h0, cond}, {31'h0, e_cond});
    chk({tag, "_hlt"}, {31'h0, hlt_ex}, {31'h0, is_hlt});
    if (ir[31:26] == 6'h0D || ir[31:26] == 6'h0E) chk({tag, "_brt"}, br_target, npc + imm);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_alu"}, ALUOut, 32'h0);
    chk({tag, "_sdata"}, store_data, 32'h0);
    chk({tag, "_ir"}, IR_ex, 32'h0);
    chk({tag, "_npc"}, NPC_ex, 32'h0);
    chk({tag, "_brt"}, br_target, 32'h0);
    chk({tag, "_flags"}, {28'h0, cond, ex_valid, hlt_ex, ex_ready}, 32'h1);
  endtask

  initial begin
    logic [5:0]  ops [16] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08,
                              6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h07, 6'h20};
    logic [31:0] ra;
    logic [31:0] held;
    int          nvalid;

    rst = 1'b1; in_valid = 1'b0; hlt = 1'b0;
    A = '0; B = '0; D = '0; Imm = '0; NPC_id = '0; IR_id = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'h0, ex_ready}, 32'd1);

    exec("add_wrap", {6'h00, 26'h0}, 32'hFFFF_FFFF, 32'd2, 32'h11, 32'h0, 32'h4, 1'b0);
    exec("slt_neg", {6'h05, 26'h1}, 32'hFFFF_FFFE, 32'd1, 32'h0, 32'h0, 32'h8, 1'b0);
    exec("slti", {6'h0A, 26'h2}, 32'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hC, 1'b0);
    exec("mul", {6'h06, 26'h3}, 32'h0001_0003, 32'h0002_0005, 32'h77, 32'h0, 32'h10, 1'b0);
    exec("add_after_mul", {6'h00, 26'h4}, 32'd10, 32'd20, 32'h0, 32'h0, 32'h14, 1'b0);
    exec("beqz_t", {6'h0D, 26'h5}, 32'd0, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h100, 1'b0);
    exec("beqz_nt", {6'h0D, 26'h6}, 32'd7, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h100, 1'b0);

    // Idle cycle: no new result, data outputs hold
    @(negedge clk);
    chk("idle_valid", {31'h0, ex_valid}, 32'd0);
    chk("idle_hold", ALUOut, 32'h0000_00F0);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      exec($sformatf("rnd%0d", i), mk(ops[$urandom_range(0, 15)]), ra, $urandom,
           $urandom, $urandom, $urandom, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        held = ALUOut;
        @(negedge clk);
        chk($sformatf("rnd%0d_gap_valid", i), {31'h0, ex_valid}, 32'd0);
        chk($sformatf("rnd%0d_gap_hold", i), ALUOut, held);
      end
    end

    // MUL of signed operands: low word matches signed product
    exec("mul_neg", {6'h06, 26'h9}, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h0, 32'h20, 1'b0);

    exec("sw", {6'h0C, 26'h7}, 32'h40, 32'h0, 32'hDEAD, 32'd8, 32'h24, 1'b0);
    exec("hlt", HltWord, 32'h5, 32'h6, 32'h0, 32'h0, 32'h28, 1'b0);
    IR_id = {6'h00, 26'h0}; A = 32'd1; B = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("halted%0d_valid", i), {31'h0, ex_valid}, 32'd0);
      chk($sformatf("halted%0d_ready", i), {31'h0, ex_ready}, 32'd0);
      chk($sformatf("halted%0d_frozen", i), IR_ex, HltWord);
      chk($sformatf("halted%0d_alu", i), ALUOut, 32'h0);
      chk($sformatf("halted%0d_hlt", i), {31'h0, hlt_ex}, 32'd1);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("halt_reset");

    // Halt raised by the flag on a non-HLT opcode
    exec("hlt_flag", {6'h00, 26'hA}, 32'd3, 32'd4, 32'h0, 32'h0, 32'h30, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("flag_reset");

    // Reset in the middle of a multiply
    IR_id = {6'h06, 26'hB}; A = 32'h1234_5678; B = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mulrst_busy", {31'h0, ex_ready}, 32'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("mulrst");
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ex_valid) nvalid++;
    end
    chk("mulrst_no_product", 32'(nvalid), 32'd0);
    chk("mulrst_alu", ALUOut, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
